sinxro_timing_gen: RTL and testbench
====================================

// Module: sinxro_timing_gen
// PURPOSE
//  Parametrised successor of the 4-phase sync generator. One-hot mux phases M, one-hot frame phases F,
//  read/buffer strobes, memory write window and board/group indexing, triggered restart on TRIG.
//  Runs on a single FRC_IN clock with an internal clock-enable divider, so there are no derived clocks.
//  Adds a one-shot frame mode with BUSY/FRAME_DONE for the acquisition controller.
// PARAMETERS
//  DIV        6   FRC_IN cycles per tick (>=2); all state advances on tick only
//  M_PHASES   4   mux phase outputs; M_PERIOD >= 2*M_PHASES
//  M_PERIOD   9   m_cnt modulus (ticks)
//  F_PHASES   6   frame phase outputs, even; F period = 2*F_PHASES ticks
//  SUB_LEN    8   sub counter modulus (ticks per group step)
//  WTM_ON     3   sub value setting WRITE_TOO_MEM; WTM_ON < WTM_OFF < SUB_LEN
//  WTM_OFF    6   sub value clearing WRITE_TOO_MEM
//  N_GROUP    3   group counter modulus
//  N_BOARD    6   boards per frame
//  ONESHOT    0   0 = continuous frames, 1 = stop after N_BOARD boards until the next trigger
// PORTS
//  FRC_IN         in   1                    clock
//  RES_HARD       in   1                    synchronous active-high reset
//  TRIG           in   1                    frame trigger, level, sampled on tick
//  COUNTER_F_GO   in   1                    enable for the F, sub and board machinery
//  M              out  M_PHASES             one-hot mux phases
//  MTR_CLK        out  1                    matrix clock, toggles on each m_cnt wrap
//  F              out  F_PHASES             one-hot frame phases
//  _RD            out  1                    active-low read strobe
//  CLK_BUFER      out  1                    buffer clock strobe
//  WRITE_BUFER    out  1                    high while sub == SUB_LEN-1
//  WRITE_TOO_MEM  out  1                    memory write window
//  GROUP_IDX      out  clog2(N_GROUP)       group counter
//  BOARD_IDX      out  clog2(N_BOARD)       board counter
//  CHENGE_ADRES   out  1                    {BOARD_IDX,GROUP_IDX} differs from its value at the previous tick
//  BUSY           out  1                    frame in progress
//  FRAME_DONE     out  1                    last board of the frame completed
// BEHAVIOUR
//  - Reset (sync, overrides everything): all counters 0; M=0, F=0, _RD=1, CLK_BUFER=0,
//    WRITE_BUFER=0, WRITE_TOO_MEM=0, indices=0, MTR_CLK=1, BUSY=0, FRAME_DONE=0, trig_d=0.
//  - tick: div counter 0..DIV-1; tick=1 when it equals DIV-1. All outputs are registered, change only
//    on tick edges and hold for DIV cycles. Reset mid-operation also clears the div counter.
//  - M path runs free, independent of GO. On tick: m_cnt=(m_cnt+1)%M_PERIOD; M[k]=1 iff new m_cnt==2k,
//    else M=0. On wrap, m_wrap toggles; MTR_CLK=~m_wrap.
//  - trig_rise = TRIG & ~trig_d; trig_d<=TRIG on each tick.
//  - Priority per tick: GO=0 > trig_rise > stopped (one-shot) > normal advance.
//  - GO=0: f_cnt, sub, group and board counters cleared; F=0; WRITE_TOO_MEM=0; BUSY=0.
//  - trig_rise with GO=1: f_cnt=0, F=1 (F[0]), sub=0, group=0, board=0, BUSY=1, WRITE_TOO_MEM=0.
//    A trigger in the same tick as a wrap wins.
//  - Normal advance (GO=1, BUSY=1 or ONESHOT=0): f_cnt=(f_cnt+1)%(2*F_PHASES). F[k]=1 iff new f_cnt==2k.
//    _RD=0 iff f_cnt%4==3; CLK_BUFER=1 iff f_cnt%4==2.
//  - sub=(sub+1)%SUB_LEN. When sub wraps, group=(group+1)%N_GROUP. WRITE_BUFER=(sub==SUB_LEN-1).
//    WRITE_TOO_MEM set when sub==WTM_ON and cleared when sub==WTM_OFF.
//  - Board: when f_cnt wraps to 0, board=(board+1)%N_BOARD. When board wraps from N_BOARD-1,
//    FRAME_DONE=1 for that tick. In ONESHOT=1, BUSY<=0; F=0, f_cnt=0 and sub=0 hold until the next
//    trig_rise, and strobes stay inactive. In ONESHOT=0, BUSY = GO after the first trigger.
//  - Before the first trigger with ONESHOT=0 and GO=1, counting starts from the reset state.
// TESTING
//  1 RES_HARD=1 for 3 cycles mid-run -> next edge: M=0, F=0, _RD=1, MTR_CLK=1, BOARD_IDX=0, BUSY=0.
//  2 GO=0, defaults -> M=0010 at tick 2, 0100 at tick 4, 1000 at tick 6, 0001 at tick 9; MTR_CLK period 108 FRC_IN cycles.
//  3 GO=1, TRIG 0->1 -> F=000001 at the sampling tick, 000010 two ticks later; _RD low at ticks 3,7,11; CLK_BUFER at ticks 2,6,10.
//  4 After trigger -> WRITE_TOO_MEM high ticks 3-5, WRITE_BUFER at tick 7, GROUP_IDX 0->1 at tick 8 with CHENGE_ADRES=1 that tick.
//  5 ONESHOT=1 -> FRAME_DONE=1 at tick 72, BUSY=0, F stays 0; second TRIG rise restarts with F=000001.
//  6 TRIG re-rise at BOARD_IDX=3 -> BOARD_IDX=0, F=000001; GO dropped -> F=0, BUSY=0 on the next tick.

Source files
------------

// File: rtl/sinxro_timing_gen_if.sv
// Bundle between the sync/timing generator and the acquisition controller.
// Ports (from the generator's point of view, modport slave):
//   trig, counter_f_go                     in   frame trigger level, F machinery enable
//   m, mtr_clk                             out  one-hot mux phases, matrix clock
//   f, rd_n, clk_bufer, write_bufer        out  one-hot frame phases, strobes
//   write_too_mem                          out  memory write window
//   group_idx, board_idx, chenge_adres     out  indexing and address-change flag
//   busy, frame_done                       out  frame status
interface sinxro_timing_gen_if #(
    parameter int M_PHASES = 4,
    parameter int F_PHASES = 6,
    parameter int N_GROUP  = 3,
    parameter int N_BOARD  = 6
);
    localparam int GW = (N_GROUP > 1) ? $clog2(N_GROUP) : 1;
    localparam int BW = (N_BOARD > 1) ? $clog2(N_BOARD) : 1;

    logic                trig;
    logic                counter_f_go;
    logic [M_PHASES-1:0] m;
    logic                mtr_clk;
    logic [F_PHASES-1:0] f;
    logic                rd_n;
    logic                clk_bufer;
    logic                write_bufer;
    logic                write_too_mem;
    logic [GW-1:0]       group_idx;
    logic [BW-1:0]       board_idx;
    logic                chenge_adres;
    logic                busy;
    logic                frame_done;

    modport master (
        output trig, counter_f_go,
        input  m, mtr_clk, f, rd_n, clk_bufer, write_bufer, write_too_mem,
        input  group_idx, board_idx, chenge_adres, busy, frame_done
    );

    modport slave (
        input  trig, counter_f_go,
        output m, mtr_clk, f, rd_n, clk_bufer, write_bufer, write_too_mem,
        output group_idx, board_idx, chenge_adres, busy, frame_done
    );
endinterface

// File: rtl/sinxro_timing_gen.sv
// Sync/timing generator: free-running one-hot mux phases with a matrix clock,
// one-hot frame phases with read/buffer strobes, a memory write window and
// board/group indexing, restarted by a rising trigger. Everything runs on
// frc_in and advances only on an internal clock-enable tick every DIV cycles.
// ONESHOT=1 stops after N_BOARD boards until the next trigger rise.
// Ports:
//   frc_in    in   clock
//   res_hard  in   synchronous active-high reset
//   bus       slave side of sinxro_timing_gen_if (trigger/enable in, phases,
//             strobes, indices and frame status out; all outputs registered)
module sinxro_timing_gen #(
    parameter int DIV      = 6,
    parameter int M_PHASES = 4,
    parameter int M_PERIOD = 9,
    parameter int F_PHASES = 6,
    parameter int SUB_LEN  = 8,
    parameter int WTM_ON   = 3,
    parameter int WTM_OFF  = 6,
    parameter int N_GROUP  = 3,
    parameter int N_BOARD  = 6,
    parameter int ONESHOT  = 0
) (
    input  logic              frc_in,
    input  logic              res_hard,
    sinxro_timing_gen_if.slave bus
);
    localparam int F_PERIOD = 2 * F_PHASES;
    localparam int DW = $clog2(DIV);
    localparam int MW = $clog2(M_PERIOD);
    localparam int FW = $clog2(F_PERIOD);
    localparam int SW = (SUB_LEN > 1) ? $clog2(SUB_LEN) : 1;
    localparam int GW = (N_GROUP > 1) ? $clog2(N_GROUP) : 1;
    localparam int BW = (N_BOARD > 1) ? $clog2(N_BOARD) : 1;
    localparam bit ONE_SHOT_MODE = (ONESHOT != 0);

    logic [DW-1:0]       div_cnt_r;
    logic [MW-1:0]       m_cnt_r;
    logic [M_PHASES-1:0] m_r;
    logic                mtr_clk_r;
    logic                trig_d_r;
    logic [FW-1:0]       f_cnt_r;
    logic [SW-1:0]       sub_r;
    logic [GW-1:0]       group_r;
    logic [BW-1:0]       board_r;
    logic [F_PHASES-1:0] f_r;
    logic                rd_n_r, clk_bufer_r, write_bufer_r, wtm_r;
    logic                chenge_r, busy_r, frame_done_r, seen_trig_r;

    logic                tick_s, trig_rise_s, m_wrap_s;
    logic [MW-1:0]       m_cnt_nx_s;
    logic [M_PHASES-1:0] m_nx_s;
    logic [FW-1:0]       f_inc_s, f_cnt_nx_s;
    logic [SW-1:0]       sub_inc_s, sub_nx_s;
    logic [GW-1:0]       group_inc_s, group_nx_s;
    logic [BW-1:0]       board_inc_s, board_nx_s;
    logic                f_wrap_s, sub_wrap_s, board_last_s, live_s;
    logic [F_PHASES-1:0] f_nx_s;
    logic                wtm_nx_s, busy_nx_s, done_nx_s, seen_nx_s;

    // Tick enable, trigger edge and the free-running mux phase counter.
    always_comb begin
        tick_s      = (div_cnt_r == DW'(DIV - 1));
        trig_rise_s = bus.trig & ~trig_d_r;
        m_wrap_s    = (m_cnt_r == MW'(M_PERIOD - 1));
        m_cnt_nx_s  = m_wrap_s ? MW'(0) : m_cnt_r + MW'(1);
        for (int k = 0; k < M_PHASES; k++) begin
            m_nx_s[k] = (m_cnt_nx_s == MW'(2 * k));
        end
    end

    // Frame machinery next state; priority GO=0 > trigger rise > stopped > advance.
    always_comb begin
        f_wrap_s     = (f_cnt_r == FW'(F_PERIOD - 1));
        f_inc_s      = f_wrap_s ? FW'(0) : f_cnt_r + FW'(1);
        sub_wrap_s   = (sub_r == SW'(SUB_LEN - 1));
        sub_inc_s    = sub_wrap_s ? SW'(0) : sub_r + SW'(1);
        if (sub_wrap_s) begin
            group_inc_s = (group_r == GW'(N_GROUP - 1)) ? GW'(0) : group_r + GW'(1);
        end else begin
            group_inc_s = group_r;
        end
        if (f_wrap_s) begin
            board_inc_s = (board_r == BW'(N_BOARD - 1)) ? BW'(0) : board_r + BW'(1);
        end else begin
            board_inc_s = board_r;
        end
        board_last_s = f_wrap_s && (board_r == BW'(N_BOARD - 1));

        f_cnt_nx_s = f_cnt_r;
        sub_nx_s   = sub_r;
        group_nx_s = group_r;
        board_nx_s = board_r;
        live_s     = 1'b0;
        wtm_nx_s   = 1'b0;
        busy_nx_s  = busy_r;
        done_nx_s  = 1'b0;
        seen_nx_s  = seen_trig_r;

        if (!bus.counter_f_go) begin
            f_cnt_nx_s = FW'(0);
            sub_nx_s   = SW'(0);
            group_nx_s = GW'(0);
            board_nx_s = BW'(0);
            busy_nx_s  = 1'b0;
        end else if (trig_rise_s) begin
            f_cnt_nx_s = FW'(0);
            sub_nx_s   = SW'(0);
            group_nx_s = GW'(0);
            board_nx_s = BW'(0);
            busy_nx_s  = 1'b1;
            seen_nx_s  = 1'b1;
            live_s     = 1'b1;
        end else if (ONE_SHOT_MODE && !busy_r) begin
            // Stopped after a completed one-shot frame: hold, strobes idle.
            live_s = 1'b0;
        end else begin
            f_cnt_nx_s = f_inc_s;
            sub_nx_s   = sub_inc_s;
            group_nx_s = group_inc_s;
            board_nx_s = board_inc_s;
            live_s     = 1'b1;
            if (sub_inc_s == SW'(WTM_ON)) begin
                wtm_nx_s = 1'b1;
            end else if (sub_inc_s == SW'(WTM_OFF)) begin
                wtm_nx_s = 1'b0;
            end else begin
                wtm_nx_s = wtm_r;
            end
            if (board_last_s) begin
                done_nx_s = 1'b1;
                if (ONE_SHOT_MODE) begin
                    busy_nx_s  = 1'b0;
                    live_s     = 1'b0;
                    f_cnt_nx_s = FW'(0);
                    sub_nx_s   = SW'(0);
                    wtm_nx_s   = 1'b0;
                end else begin
                    busy_nx_s = seen_trig_r;
                end
            end else begin
                busy_nx_s = ONE_SHOT_MODE ? 1'b1 : seen_trig_r;
            end
        end

        for (int k = 0; k < F_PHASES; k++) begin
            f_nx_s[k] = live_s && (f_cnt_nx_s == FW'(2 * k));
        end
    end

    // State and registered outputs; everything updates only on tick.
    always_ff @(posedge frc_in) begin
        if (res_hard) begin
            div_cnt_r     <= DW'(0);
            m_cnt_r       <= MW'(0);
            m_r           <= {M_PHASES{1'b0}};
            mtr_clk_r     <= 1'b1;
            trig_d_r      <= 1'b0;
            f_cnt_r       <= FW'(0);
            sub_r         <= SW'(0);
            group_r       <= GW'(0);
            board_r       <= BW'(0);
            f_r           <= {F_PHASES{1'b0}};
            rd_n_r        <= 1'b1;
            clk_bufer_r   <= 1'b0;
            write_bufer_r <= 1'b0;
            wtm_r         <= 1'b0;
            chenge_r      <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            seen_trig_r   <= 1'b0;
        end else begin
            div_cnt_r <= tick_s ? DW'(0) : div_cnt_r + DW'(1);
            if (tick_s) begin
                m_cnt_r <= m_cnt_nx_s;
                m_r     <= m_nx_s;
                if (m_wrap_s) begin
                    mtr_clk_r <= ~mtr_clk_r;
                end
                trig_d_r      <= bus.trig;
                f_cnt_r       <= f_cnt_nx_s;
                sub_r         <= sub_nx_s;
                group_r       <= group_nx_s;
                board_r       <= board_nx_s;
                f_r           <= f_nx_s;
                rd_n_r        <= ~(live_s && (f_cnt_nx_s[1:0] == 2'd3));
                clk_bufer_r   <= live_s && (f_cnt_nx_s[1:0] == 2'd2);
                write_bufer_r <= live_s && (sub_nx_s == SW'(SUB_LEN - 1));
                wtm_r         <= wtm_nx_s;
                chenge_r      <= ({board_nx_s, group_nx_s} != {board_r, group_r});
                busy_r        <= busy_nx_s;
                frame_done_r  <= done_nx_s;
                seen_trig_r   <= seen_nx_s;
            end
        end
    end

    assign bus.m             = m_r;
    assign bus.mtr_clk       = mtr_clk_r;
    assign bus.f             = f_r;
    assign bus.rd_n          = rd_n_r;
    assign bus.clk_bufer     = clk_bufer_r;
    assign bus.write_bufer   = write_bufer_r;
    assign bus.write_too_mem = wtm_r;
    assign bus.group_idx     = group_r;
    assign bus.board_idx     = board_r;
    assign bus.chenge_adres  = chenge_r;
    assign bus.busy          = busy_r;
    assign bus.frame_done    = frame_done_r;
endmodule

// File: tb/tb_sinxro_timing_gen.sv
// Bench for sinxro_timing_gen: a continuous-mode and a one-shot instance share
// clock, reset, trigger and enable. Every cycle the bench model's expected
// outputs are queued before the clock edge and compared after it; directed
// checks anchor the key timing points.
module tb_sinxro_timing_gen;
    localparam int DIV = 6;
    localparam int M_PER = 9;
    localparam int F_PER = 12;
    localparam int SUB_LEN = 8;
    localparam int N_GROUP = 3;
    localparam int N_BOARD = 6;
    localparam int FRAME_TICKS = F_PER * N_BOARD;

    typedef struct packed {
        logic [3:0] m;
        logic       mtr;
        logic [5:0] f;
        logic       rd_n, clkb, wrb, wtm;
        logic [1:0] grp;
        logic [2:0] brd;
        logic       chg, busy, done;
    } exp_t;

    logic frc_in = 1'b0;
    logic res_hard, trig, go;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    int bdiv, n_tick, tick_ev;
    bit m_live, trig_d_m;
    int t[2];
    bit live[2], busy[2], seen[2], done[2], chg[2];
    int prev_addr[2];

    always #5 frc_in = ~frc_in;

    sinxro_timing_gen_if #(.M_PHASES(4), .F_PHASES(6), .N_GROUP(3), .N_BOARD(6)) bus_c ();
    sinxro_timing_gen_if #(.M_PHASES(4), .F_PHASES(6), .N_GROUP(3), .N_BOARD(6)) bus_o ();
    assign bus_c.trig = trig;
    assign bus_c.counter_f_go = go;
    assign bus_o.trig = trig;
    assign bus_o.counter_f_go = go;

    sinxro_timing_gen #(.ONESHOT(0)) dut_c (.frc_in(frc_in), .res_hard(res_hard), .bus(bus_c));
    sinxro_timing_gen #(.ONESHOT(1)) dut_o (.frc_in(frc_in), .res_hard(res_hard), .bus(bus_o));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bdiv = 0; n_tick = 0; m_live = 1'b0; trig_d_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t[i] = 0; live[i] = 1'b0; busy[i] = 1'b0; seen[i] = 1'b0;
            done[i] = 1'b0; chg[i] = 1'b0; prev_addr[i] = 0;
        end
    endtask

    task automatic model_tick();
        bit rise;
        int addr;
        tick_ev++;
        n_tick++;
        m_live = 1'b1;
        rise = trig && !trig_d_m;
        for (int i = 0; i < 2; i++) begin
            if (!go) begin
                t[i] = 0; busy[i] = 1'b0; live[i] = 1'b0; done[i] = 1'b0;
            end else if (rise) begin
                t[i] = 0; busy[i] = 1'b1; seen[i] = 1'b1; live[i] = 1'b1; done[i] = 1'b0;
            end else if (i == 1 && !busy[i]) begin
                live[i] = 1'b0; done[i] = 1'b0;
            end else begin
                t[i] = (t[i] + 1) % FRAME_TICKS;
                done[i] = (t[i] == 0);
                if (i == 1 && done[i]) begin
                    busy[i] = 1'b0; live[i] = 1'b0;
                end else begin
                    live[i] = 1'b1;
                    busy[i] = (i == 1) ? 1'b1 : seen[i];
                end
            end
            addr = ((t[i] / F_PER) % N_BOARD) * 4 + (t[i] / SUB_LEN) % N_GROUP;
            chg[i] = (addr != prev_addr[i]);
            prev_addr[i] = addr;
        end
        trig_d_m = trig;
    endtask

    function automatic exp_t model_out(int i);
        exp_t e;
        int fc, sb, mc;
        fc = t[i] % F_PER;
        sb = t[i] % SUB_LEN;
        mc = n_tick % M_PER;
        e.m    = (m_live && (mc % 2 == 0) && (mc < 8)) ? 4'(1 << (mc / 2)) : 4'b0000;
        e.mtr  = ((n_tick / M_PER) % 2) == 0;
        e.f    = (live[i] && (fc % 2 == 0)) ? 6'(1 << (fc / 2)) : 6'b000000;
        e.rd_n = !(live[i] && (fc % 4 == 3));
        e.clkb = live[i] && (fc % 4 == 2);
        e.wrb  = live[i] && (sb == SUB_LEN - 1);
        e.wtm  = live[i] && (sb >= 3) && (sb < 6);
        e.grp  = 2'((t[i] / SUB_LEN) % N_GROUP);
        e.brd  = 3'((t[i] / F_PER) % N_BOARD);
        e.chg  = chg[i];
        e.busy = busy[i];
        e.done = done[i];
        return e;
    endfunction

    function automatic exp_t actual_c();
        return '{bus_c.m, bus_c.mtr_clk, bus_c.f, bus_c.rd_n, bus_c.clk_bufer, bus_c.write_bufer,
                 bus_c.write_too_mem, bus_c.group_idx, bus_c.board_idx, bus_c.chenge_adres,
                 bus_c.busy, bus_c.frame_done};
    endfunction

    function automatic exp_t actual_o();
        return '{bus_o.m, bus_o.mtr_clk, bus_o.f, bus_o.rd_n, bus_o.clk_bufer, bus_o.write_bufer,
                 bus_o.write_too_mem, bus_o.group_idx, bus_o.board_idx, bus_o.chenge_adres,
                 bus_o.busy, bus_o.frame_done};
    endfunction

    task automatic compare(input string who, input exp_t a, input exp_t e);
        check({who, "_m"}, 32'(a.m), 32'(e.m));
        check({who, "_mtr_clk"}, 32'(a.mtr), 32'(e.mtr));
        check({who, "_f"}, 32'(a.f), 32'(e.f));
        check({who, "_rd_n"}, 32'(a.rd_n), 32'(e.rd_n));
        check({who, "_clk_bufer"}, 32'(a.clkb), 32'(e.clkb));
        check({who, "_write_bufer"}, 32'(a.wrb), 32'(e.wrb));
        check({who, "_write_too_mem"}, 32'(a.wtm), 32'(e.wtm));
        check({who, "_group_idx"}, 32'(a.grp), 32'(e.grp));
        check({who, "_board_idx"}, 32'(a.brd), 32'(e.brd));
        check({who, "_chenge_adres"}, 32'(a.chg), 32'(e.chg));
        check({who, "_busy"}, 32'(a.busy), 32'(e.busy));
        check({who, "_frame_done"}, 32'(a.done), 32'(e.done));
    endtask

    // One clock: advance the model, queue expectations, compare after the edge.
    task automatic cycle();
        if (res_hard) begin
            model_reset();
        end else if (bdiv == DIV - 1) begin
            bdiv = 0;
            model_tick();
        end else begin
            bdiv++;
        end
        sb_q.push_back(model_out(0));
        sb_q.push_back(model_out(1));
        @(posedge frc_in);
        #1;
        compare("cont", actual_c(), sb_q.pop_front());
        compare("oneshot", actual_o(), sb_q.pop_front());
        @(negedge frc_in);
    endtask

    task automatic run_ticks(input int k);
        int target;
        int guard;
        target = tick_ev + k;
        guard = 0;
        while (tick_ev < target && guard < (k + 1) * DIV) begin
            cycle();
            guard++;
        end
    endtask

    initial begin
        tick_ev = 0;
        model_reset();
        trig = 1'b0;
        go = 1'b0;
        res_hard = 1'b1;
        @(negedge frc_in);
        repeat (3) cycle();
        res_hard = 1'b0;
        check("rst_m", 32'(bus_c.m), 32'd0);
        check("rst_mtr_clk", 32'(bus_c.mtr_clk), 32'd1);
        check("rst_rd_n", 32'(bus_o.rd_n), 32'd1);

        // Mux phases with GO low.
        run_ticks(2); check("t2_m", 32'(bus_c.m), 32'b0010);
        run_ticks(2); check("t4_m", 32'(bus_c.m), 32'b0100);
        run_ticks(2); check("t6_m", 32'(bus_c.m), 32'b1000);
        run_ticks(3); check("t9_m", 32'(bus_c.m), 32'b0001);
        check("t9_mtr_clk", 32'(bus_c.mtr_clk), 32'd0);
        run_ticks(9); check("t18_mtr_clk", 32'(bus_c.mtr_clk), 32'd1);

        // GO high, free counting, then trigger.
        go = 1'b1;
        run_ticks(5);
        trig = 1'b1;
        run_ticks(1);
        check("trig_f", 32'(bus_c.f), 32'b000001);
        check("trig_busy_o", 32'(bus_o.busy), 32'd1);
        run_ticks(2); check("trig2_f", 32'(bus_o.f), 32'b000010);
        check("trig2_clk_bufer", 32'(bus_c.clk_bufer), 32'd1);
        run_ticks(1); check("trig3_rd_n", 32'(bus_c.rd_n), 32'd0);
        check("trig3_wtm", 32'(bus_c.write_too_mem), 32'd1);
        run_ticks(4); check("trig7_write_bufer", 32'(bus_o.write_bufer), 32'd1);
        run_ticks(1); check("trig8_group", 32'(bus_c.group_idx), 32'd1);
        check("trig8_chenge", 32'(bus_c.chenge_adres), 32'd1);
        run_ticks(64);
        check("t72_done_o", 32'(bus_o.frame_done), 32'd1);
        check("t72_busy_o", 32'(bus_o.busy), 32'd0);
        check("t72_f_o", 32'(bus_o.f), 32'd0);
        check("t72_done_c", 32'(bus_c.frame_done), 32'd1);
        run_ticks(12); check("stopped_f_o", 32'(bus_o.f), 32'd0);

        // Second trigger rise restarts the one-shot frame.
        trig = 1'b0; run_ticks(1);
        trig = 1'b1; run_ticks(1);
        check("retrig_f_o", 32'(bus_o.f), 32'b000001);
        check("retrig_busy_o", 32'(bus_o.busy), 32'd1);

        // Re-trigger mid-frame, then drop GO.
        run_ticks(36); check("b3_board", 32'(bus_c.board_idx), 32'd3);
        trig = 1'b0; run_ticks(1);
        trig = 1'b1; run_ticks(1);
        check("rt_board", 32'(bus_c.board_idx), 32'd0);
        check("rt_f", 32'(bus_c.f), 32'b000001);
        go = 1'b0; run_ticks(1);
        check("nogo_f", 32'(bus_c.f), 32'd0);
        check("nogo_busy", 32'(bus_c.busy), 32'd0);

        // Reset in the middle of a tick period while running.
        trig = 1'b0;
        go = 1'b1;
        run_ticks(7);
        repeat (2) cycle();
        res_hard = 1'b1;
        cycle();
        check("mid_rst_m", 32'(bus_c.m), 32'd0);
        check("mid_rst_f", 32'(bus_c.f), 32'd0);
        check("mid_rst_board", 32'(bus_c.board_idx), 32'd0);
        check("mid_rst_busy", 32'(bus_c.busy), 32'd0);
        repeat (2) cycle();
        res_hard = 1'b0;
        run_ticks(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
